// File: rtl/core_if_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_if_buf_pkg
//  Purpose  : Shared constants and types for the in-order fetch buffer.
//             IF_BUF_DEPTH - default number of buffer slots (power of 2, >= 2)
//             NOP_INSTR    - instruction presented to decode when idle
//             PC_START     - reset fetch address of the core
//             if_mode_e    - NORMAL (no stale acks owed) / DRAIN (stale acks owed)
//  Revision : 1.0 - initial release
// ============================================================================
package core_if_buf_pkg;

    localparam int          IF_BUF_DEPTH = 4;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] PC_START     = 32'h0000_0000;

    typedef enum logic [0:0] {
        MODE_NORMAL = 1'b0,
        MODE_DRAIN  = 1'b1
    } if_mode_e;

endpackage : core_if_buf_pkg
`default_nettype wire

// File: rtl/core_if_buf_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : core_if_buf_ptr
//  Purpose  : Wrapping pointer counter used for the alloc/fill/rd pointers of
//             the fetch buffer. Width carries one extra wrap bit so the parent
//             can tell full from empty by subtraction.
//  Ports    : clk     - clock
//             rst     - synchronous active-high reset (clears to 0)
//             clr_in  - synchronous clear (flush)
//             inc_in  - advance by one (modulo 2^W)
//             cnt_out - current pointer value
//  Revision : 1.0 - initial release
// ============================================================================
module core_if_buf_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_in,
    input  logic         inc_in,
    output logic [W-1:0] cnt_out
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_in) begin
            cnt_d = '0;
        end else if (inc_in) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_out = cnt_q;

endmodule : core_if_buf_ptr
`default_nettype wire

// File: rtl/core_if_buf.sv
`default_nettype none
// ============================================================================
//  Module   : core_if_buf
//  Purpose  : In-order fetch buffer between fetch/L1I and decode. A slot is
//             allocated per issued fetch PC, filled when L1I returns the word,
//             and presented to decode as {instr, pc, pc+4} with valid/ready.
//             After a redirect flush the acks still owed by L1I for killed
//             fetches are counted and discarded.
//  Ports    : clk, rst                   - clock, sync active-high reset
//             flush_in                   - redirect: drop buffered + in-flight
//             req_val_in/req_addr_in     - fetch issued to L1I this cycle
//             req_rdy_out                - slot available for a new fetch
//             l1i_ack_in/l1i_data_in     - in-order instruction return
//             dec_val_out/dec_rdy_in     - decode handshake on head slot
//             dec_instr_out/dec_pc_out/dec_pc_4_out - head slot contents
//  Revision : 1.0 - initial release
// ============================================================================
module core_if_buf
    import core_if_buf_pkg::*;
#(
    parameter int DEPTH = IF_BUF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_in,
    input  logic        req_val_in,
    input  logic [31:0] req_addr_in,
    output logic        req_rdy_out,
    input  logic        l1i_ack_in,
    input  logic [31:0] l1i_data_in,
    output logic        dec_val_out,
    input  logic        dec_rdy_in,
    output logic [31:0] dec_instr_out,
    output logic [31:0] dec_pc_out,
    output logic [31:0] dec_pc_4_out
);

    localparam int CW = PTR_W + 1;

    // Slot storage
    logic [31:0]      pc_q     [DEPTH];
    logic [31:0]      pc_d     [DEPTH];
    logic [31:0]      instr_q  [DEPTH];
    logic [31:0]      instr_d  [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [DEPTH-1:0] filled_d;
    logic [CW-1:0]    drop_cnt_q;
    logic [CW-1:0]    drop_cnt_d;

    logic [CW-1:0]    alloc_ptr;
    logic [CW-1:0]    fill_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    used;
    logic [CW-1:0]    pend;
    logic [CW-1:0]    drop_tot;
    logic [CW:0]      occupancy;
    if_mode_e         mode;
    logic             accept;
    logic             ack_fill;
    logic             ack_drop;
    logic             consume;
    logic [31:0]      head_pc;

    assign used      = alloc_ptr - rd_ptr;
    assign pend      = alloc_ptr - fill_ptr;
    // Killed fetches still owed by L1I; bounded by DEPTH because requests
    // are only accepted while used + drop_cnt < DEPTH.
    assign drop_tot  = drop_cnt_q + pend;
    assign occupancy = {1'b0, used} + {1'b0, drop_cnt_q};
    assign mode      = (drop_cnt_q != '0) ? MODE_DRAIN : MODE_NORMAL;

    // Capacity counts stale acks too, so a new fetch can never find its slot
    // still awaiting an old wrong-path word.
    assign req_rdy_out = ~rst & (occupancy < (CW+1)'(DEPTH));

    assign accept   = req_val_in & req_rdy_out & ~flush_in;
    assign ack_drop = l1i_ack_in & ~flush_in & (mode == MODE_DRAIN);
    // An ack with nothing pending is a protocol error and is ignored.
    assign ack_fill = l1i_ack_in & ~flush_in & (mode == MODE_NORMAL) & (pend != '0);
    assign consume  = dec_val_out & dec_rdy_in & ~flush_in;

    core_if_buf_ptr #(.W(CW)) u_alloc_ptr (
        .clk     (clk),
        .rst     (rst),
        .clr_in  (flush_in),
        .inc_in  (accept),
        .cnt_out (alloc_ptr)
    );

    core_if_buf_ptr #(.W(CW)) u_fill_ptr (
        .clk     (clk),
        .rst     (rst),
        .clr_in  (flush_in),
        .inc_in  (ack_fill),
        .cnt_out (fill_ptr)
    );

    core_if_buf_ptr #(.W(CW)) u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .clr_in  (flush_in),
        .inc_in  (consume),
        .cnt_out (rd_ptr)
    );

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        filled_d   = filled_q;
        drop_cnt_d = drop_cnt_q;
        if (flush_in) begin
            filled_d = '0;
            // A coincident ack belongs to the oldest owed fetch, so it is
            // consumed from the new owed total right away.
            if (l1i_ack_in && (drop_tot != '0)) begin
                drop_cnt_d = drop_tot - 1'b1;
            end else begin
                drop_cnt_d = drop_tot;
            end
        end else begin
            if (consume) begin
                filled_d[rd_ptr[PTR_W-1:0]] = 1'b0;
            end
            if (ack_fill) begin
                instr_d[fill_ptr[PTR_W-1:0]]  = l1i_data_in;
                filled_d[fill_ptr[PTR_W-1:0]] = 1'b1;
            end
            if (ack_drop) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (accept) begin
                pc_d[alloc_ptr[PTR_W-1:0]]     = req_addr_in;
                filled_d[alloc_ptr[PTR_W-1:0]] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            filled_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            filled_q   <= filled_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Head slot presentation; filled bits are cleared on consume/flush, so
    // the head's filled bit alone qualifies the output.
    assign dec_val_out   = filled_q[rd_ptr[PTR_W-1:0]];
    assign head_pc       = pc_q[rd_ptr[PTR_W-1:0]];
    assign dec_instr_out = dec_val_out ? instr_q[rd_ptr[PTR_W-1:0]] : NOP_INSTR;
    assign dec_pc_out    = dec_val_out ? head_pc : 32'h0;
    assign dec_pc_4_out  = dec_val_out ? (head_pc + 32'd4) : 32'h0;

endmodule : core_if_buf
`default_nettype wire
